// File: rtl/booth_div.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient
// bit per clock, followed by a sign-correction step.
module booth_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             parser_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             alu_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] dreg;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;
  logic             zero_pend;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;

  // Magnitudes of the most-negative value still fit as unsigned WIDTH bits.
  assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;

  assign shifted  = {prem, dreg[WIDTH-1]};
  assign trial    = shifted[WIDTH:0] - {1'b0, dvs};
  assign trial_ok = (shifted >= {2'b00, dvs});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      prem        <= '0;
      dreg        <= '0;
      dvs         <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_pend   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      alu_done    <= 1'b0;
    end else if (parser_done) begin
      // A zero divisor keeps the raw dividend so it can be returned as the remainder.
      dreg        <= (divisor == '0) ? dividend : dividend_mag;
      dvs         <= divisor_mag;
      sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      sign_r      <= dividend[WIDTH-1];
      prem        <= '0;
      cnt         <= CW'(WIDTH - 1);
      alu_done    <= 1'b0;
      div_by_zero <= 1'b0;
      zero_pend   <= (divisor == '0);
      state       <= (divisor == '0) ? DONE : CALC;
    end else begin
      case (state)
        CALC: begin
          dreg <= {dreg[WIDTH-2:0], trial_ok};
          prem <= trial_ok ? trial : shifted[WIDTH:0];
          cnt  <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          quotient  <= sign_q ? -dreg : dreg;
          remainder <= sign_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
          alu_done  <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // Divide-by-zero results are published one cycle after the start edge.
          if (zero_pend) begin
            quotient    <= '1;
            remainder   <= dreg;
            div_by_zero <= 1'b1;
            alu_done    <= 1'b1;
            zero_pend   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_div.sv
// Directed, table-driven bench for booth_div plus abort, reset and held-start sequences.
module tb_booth_div;

  logic        clk;
  logic        rst;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        parser_done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        alu_done;

  int errors = 0;
  int checks = 0;
  logic saw_333 = 1'b0;
  logic [15:0] prev_q = 16'h0000;
  logic [15:0] prev_r = 16'h0000;

  typedef struct {
    logic [15:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  booth_div #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .dividend(dividend),
    .divisor(divisor),
    .parser_done(parser_done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .alu_done(alu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one start pulse; returns #1 after the start edge k.
  task automatic applyStimulus(input logic [15:0] dvd, input logic [15:0] dvs);
    dividend    = dvd;
    divisor     = dvs;
    parser_done = 1'b1;
    @(posedge clk);
    #1;
    parser_done = 1'b0;
  endtask

  task automatic waitDone(input logic check_busy, output int n);
    n = 0;
    while (!alu_done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (quotient == 16'd333) saw_333 = 1'b1;
      if (check_busy && n == 8) begin
        checkOutput("busy_done_low", {15'b0, alu_done}, 16'h0000);
        checkOutput("busy_q_hold", quotient, prev_q);
        checkOutput("busy_r_hold", remainder, prev_r);
        checkOutput("busy_dz_clear", {15'b0, div_by_zero}, 16'h0000);
      end
    end
  endtask

  initial begin
    int n;
    logic seen_done;

    vecs[0]  = '{16'd100,   16'd7,      16'd14,   16'd2,    1'b0, 17};
    vecs[1]  = '{16'hFFF9,  16'd2,      16'hFFFD, 16'hFFFF, 1'b0, 17};
    vecs[2]  = '{16'd7,     16'hFFFE,   16'hFFFD, 16'h0001, 1'b0, 17};
    vecs[3]  = '{16'hFFF9,  16'hFFFE,   16'h0003, 16'hFFFF, 1'b0, 17};
    vecs[4]  = '{16'h1234,  16'h0000,   16'hFFFF, 16'h1234, 1'b1, 1};
    vecs[5]  = '{16'd9,     16'd3,      16'd3,    16'd0,    1'b0, 17};
    vecs[6]  = '{16'h8000,  16'hFFFF,   16'h8000, 16'h0000, 1'b0, 17};
    vecs[7]  = '{16'h8000,  16'h0001,   16'h8000, 16'h0000, 1'b0, 17};
    vecs[8]  = '{16'd5,     16'd9,      16'd0,    16'd5,    1'b0, 17};
    vecs[9]  = '{16'd32767, 16'd32767,  16'd1,    16'd0,    1'b0, 17};
    vecs[10] = '{16'hFF9C,  16'd7,      16'hFFF2, 16'hFFFE, 1'b0, 17};
    vecs[11] = '{16'd0,     16'd5,      16'd0,    16'd0,    1'b0, 17};

    rst = 1'b1;
    parser_done = 1'b0;
    dividend = 16'h0;
    divisor = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_q", quotient, 16'h0000);
    checkOutput("reset_r", remainder, 16'h0000);
    checkOutput("reset_dz", {15'b0, div_by_zero}, 16'h0000);
    checkOutput("reset_done", {15'b0, alu_done}, 16'h0000);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].dvd, vecs[i].dvs);
      checkOutput("start_done_low", {15'b0, alu_done}, 16'h0000);
      waitDone(vecs[i].lat > 1, n);
      checkOutput($sformatf("latency_%0d", i), n[15:0], vecs[i].lat[15:0]);
      checkOutput($sformatf("quot_%0d", i), quotient, vecs[i].q);
      checkOutput($sformatf("rem_%0d", i), remainder, vecs[i].r);
      checkOutput($sformatf("dz_%0d", i), {15'b0, div_by_zero}, {15'b0, vecs[i].dz});
      checkOutput($sformatf("done_%0d", i), {15'b0, alu_done}, 16'h0001);
      if (i == 0) begin
        repeat (10) @(posedge clk);
        #1;
        checkOutput("hold_q", quotient, vecs[i].q);
        checkOutput("hold_r", remainder, vecs[i].r);
        checkOutput("hold_done", {15'b0, alu_done}, 16'h0001);
      end
      prev_q = vecs[i].q;
      prev_r = vecs[i].r;
    end

    // Abort: restart with 50/4 during cycle 8 of the 1000/3 computation.
    saw_333 = 1'b0;
    applyStimulus(16'd1000, 16'd3);
    repeat (7) begin
      @(posedge clk);
      #1;
      if (quotient == 16'd333) saw_333 = 1'b1;
    end
    applyStimulus(16'd50, 16'd4);
    waitDone(1'b1, n);
    checkOutput("abort_latency", n[15:0], 16'd17);
    checkOutput("abort_q", quotient, 16'd12);
    checkOutput("abort_r", remainder, 16'd2);
    repeat (20) begin
      @(posedge clk);
      #1;
      if (quotient == 16'd333) saw_333 = 1'b1;
    end
    checkOutput("abort_no_333", {15'b0, saw_333}, 16'h0000);

    // Reset mid-CALC clears outputs immediately and no result follows.
    applyStimulus(16'd1000, 16'd3);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_q", quotient, 16'h0000);
    checkOutput("midrst_r", remainder, 16'h0000);
    checkOutput("midrst_done", {15'b0, alu_done}, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (alu_done) seen_done = 1'b1;
    end
    checkOutput("midrst_no_done", {15'b0, seen_done}, 16'h0000);
    checkOutput("midrst_q_after", quotient, 16'h0000);
    prev_q = 16'h0000;
    prev_r = 16'h0000;
    applyStimulus(16'd9, 16'd3);
    waitDone(1'b1, n);
    checkOutput("post_rst_latency", n[15:0], 16'd17);
    checkOutput("post_rst_q", quotient, 16'd3);
    checkOutput("post_rst_r", remainder, 16'd0);

    // parser_done held for three cycles: only the last operands count.
    prev_q = 16'd3;
    prev_r = 16'd0;
    dividend = 16'd1000;
    divisor = 16'd3;
    parser_done = 1'b1;
    @(posedge clk);
    #1;
    dividend = 16'd77;
    divisor = 16'd5;
    @(posedge clk);
    #1;
    dividend = 16'd20;
    divisor = 16'd6;
    @(posedge clk);
    #1;
    parser_done = 1'b0;
    waitDone(1'b1, n);
    checkOutput("held_latency", n[15:0], 16'd17);
    checkOutput("held_q", quotient, 16'd3);
    checkOutput("held_r", remainder, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_div.md
Name: booth_div

Overview:
- Sequential signed integer divider for the UART hex calculator ALU path; the inverse operation to the shift-add multiplier.
- Started by the same parser_done strobe and reports completion through the same level-style alu_done flag, so the ALU result mux treats multiply and divide identically.
- Computes quotient and remainder of two two's-complement operands by restoring division on magnitudes, one quotient bit per clock, then applies sign correction.

Parameters:
- WIDTH, 16, operand and result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- dividend  input  WIDTH  signed dividend, sampled only on the parser_done edge
- divisor  input  WIDTH  signed divisor, sampled only on the parser_done edge
- parser_done  input  1  start strobe; one-cycle pulse from the parser
- quotient  output  WIDTH  signed quotient, registered
- remainder  output  WIDTH  signed remainder, registered
- div_by_zero  output  1  set when the last operation had divisor == 0
- alu_done  output  1  level high while a valid result is held

Behaviour:
- Reset (rst high, asynchronous): state = IDLE, quotient = 0, remainder = 0, div_by_zero = 0, alu_done = 0, internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- Start: on any clock edge with parser_done = 1, from any state including CALC and FIX:
  - capture |dividend| and |divisor| as WIDTH-bit unsigned values, plus sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend);
  - clear the partial remainder (WIDTH+1 bits), set cnt = WIDTH-1, alu_done = 0, div_by_zero = 0;
  - go to CALC, or go to DONE if divisor == 0 (see below).
  - A start during CALC or FIX aborts the current operation; nothing from it reaches the outputs.
- CALC, one step per cycle:
  - shift {partial remainder, dividend register} left by 1;
  - trial = partial remainder - |divisor|;
  - if trial is non-negative, partial remainder = trial and quotient bit = 1; otherwise restore and quotient bit = 0;
  - decrement cnt; at cnt == 0 the step executes and the next state is FIX.
- FIX:
  - quotient = sign_q ? -Qmag : Qmag;
  - remainder = sign_r ? -Rmag : Rmag;
  - alu_done = 1; go to DONE.
- Latency: parser_done sampled at edge k gives alu_done = 1 after edge k+WIDTH+1 (k+17 for WIDTH = 16). quotient and remainder change only at that same edge.
- DONE: outputs and alu_done hold until the next parser_done or reset. IDLE is left only by parser_done.
- While busy (CALC or FIX): quotient and remainder hold the previous result; alu_done = 0.
- Divide by zero (divisor == 0 at the start edge), no iteration:
  - after edge k+1: quotient = all ones, remainder = dividend unchanged, div_by_zero = 1, alu_done = 1, state DONE.
- Rounding: truncation toward zero. The remainder takes the sign of the dividend or is zero. Invariant: dividend = quotient*divisor + remainder (mod 2^WIDTH).
- Most-negative operand: |−2^(WIDTH−1)| = 2^(WIDTH−1) is representable as unsigned WIDTH bits.
  - −32768 / −1 gives quotient 16'h8000 (wraps), remainder 0, no flag.
- parser_done held high for several cycles: the block restarts on every cycle it is high; the result is computed from the operands on the last high cycle.
- Reset asserted mid-operation: immediate return to reset values; no result is produced.

Test Plan:
- Reset released, then dividend=100, divisor=7, parser_done pulse at edge k -> alu_done 0 through edge k+16, 1 after edge k+17; quotient=14, remainder=2, div_by_zero=0; values hold 10 further cycles.
- Signs: −7/2 -> quotient=16'hFFFD (−3), remainder=16'hFFFF (−1); 7/−2 -> 16'hFFFD, 16'h0001; −7/−2 -> 16'h0003, 16'hFFFF.
- dividend=16'h1234, divisor=0 -> after edge k+1: alu_done=1, div_by_zero=1, quotient=16'hFFFF, remainder=16'h1234; a following 9/3 clears div_by_zero and gives quotient 3, remainder 0.
- Extremes:
  - −32768/−1 -> quotient 16'h8000, remainder 0;
  - −32768/1 -> quotient 16'h8000, remainder 0;
  - 5/9 -> quotient 0, remainder 5;
  - 32767/32767 -> quotient 1, remainder 0.
- Start 1000/3, reissue parser_done with 50/4 at cycle 8 of CALC -> no 333/1 ever appears; quotient=12, remainder=2, alu_done high 17 cycles after the second pulse.
- Start 1000/3, assert rst for one cycle mid-CALC -> outputs return to 0 immediately and alu_done stays 0 until a new parser_done.
